// File: rtl/rca_seq_adder.sv
// Purpose: WIDTH-bit adder sequenced over one shared 4-bit ripple-carry slice, LSB nibble first.
// Latency: sum_valid rises NIB cycles after the accept edge; initiation interval is at least NIB+2 cycles.
// Backpressure: result is held in DONE until sum_ready; start_ready is low in RUN and DONE. Optional RCA_SEQ_SUB_EN adds subtract.
module rca_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       slice_s;
    logic [3:0]       slice_c;

    // Shared 4-bit ripple slice on the current nibble, seeded by the carry register.
    always_comb begin
        logic c;
        nib_a   = a_q[4*idx_q +: 4];
        nib_b   = b_q[4*idx_q +: 4];
        slice_s = '0;
        slice_c = '0;
        c       = carry_q;
        for (int i = 0; i < 4; i++) begin
            slice_s[i] = nib_a[i] ^ nib_b[i] ^ c;
            slice_c[i] = ((nib_a[i] ^ nib_b[i]) & c) | (nib_a[i] & nib_b[i]);
            c          = slice_c[i];
        end
    end

    // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    a_d     = a;
`ifdef RCA_SEQ_SUB_EN
                    // Subtract as a + ~b + 1; cin is ignored in that mode.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[4*idx_q +: 4] = slice_s;
                carry_d             = slice_c[3];
                idx_d               = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    // Carry into the MSB is slice carry bit 2.
                    cout_d  = slice_c[3];
                    ovf_d   = slice_c[2] ^ slice_c[3];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (sum_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign sum_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// Purpose: directed self-checking bench for rca_seq_adder at WIDTH=16.
// Latency: expects sum_valid exactly 4 cycles after each accept edge.
// Backpressure: holds sum_ready low in DONE and probes start_ready/start_valid there.
module tb_rca_seq_adder;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
`ifdef RCA_SEQ_SUB_EN
    logic        sub;
`endif
    logic        sum_valid;
    logic        sum_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    rca_seq_adder #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
`ifdef RCA_SEQ_SUB_EN
        .sub         (sub),
`endif
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts one operation, checks latency and result, then drains it.
    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic [15:0] es, input logic ec, input logic eo);
        int cnt;
        a           = av;
        b           = bv;
        cin         = cv;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        a           = ~av;
        b           = ~bv;
        cin         = ~cv;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_sum_clr"}, {16'd0, sum}, 32'd0);
        cnt = 0;
        while (!sum_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 32'd4);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk({tag, "_vld_low"}, {31'd0, sum_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, start_ready}, 32'd1);
        chk({tag, "_sum_held"}, {16'd0, sum}, {16'd0, es});
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        sum_ready   = 1'b0;
        a           = 16'h0;
        b           = 16'h0;
        cin         = 1'b0;
`ifdef RCA_SEQ_SUB_EN
        sub         = 1'b0;
`endif
        tick();
        tick();

        // Reset values.
        chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
        chk("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;

        // sum_ready in IDLE must not disturb anything.
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("idle_ready_ignored", {31'd0, start_ready}, 32'd1);

        do_op("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("sovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_op("cin",    16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Backpressure: result held while sum_ready is low for 5 cycles.
        a           = 16'h00FF;
        b           = 16'h0001;
        cin         = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 20 && !sum_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            a           = 16'h1111;
            b           = 16'h2222;
            start_valid = (i == 2);
            chk("bp_valid", {31'd0, sum_valid}, 32'd1);
            chk("bp_sum", {16'd0, sum}, 32'h0101);
            chk("bp_start_ready", {31'd0, start_ready}, 32'd0);
            tick();
        end
        start_valid = 1'b0;
        chk("bp_still_valid", {31'd0, sum_valid}, 32'd1);
        chk("bp_cout", {31'd0, cout}, 32'd0);
        chk("bp_ovf", {31'd0, ovf}, 32'd0);
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        chk("bp_release_valid", {31'd0, sum_valid}, 32'd0);
        chk("bp_release_idle", {31'd0, start_ready}, 32'd1);
        chk("bp_release_sum", {16'd0, sum}, 32'h0101);

        // Reset asserted during the second RUN cycle abandons the operation.
        a           = 16'h1234;
        b           = 16'h1111;
        cin         = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_ready", {31'd0, start_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, sum_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_sum", {16'd0, sum}, 32'd0);
        chk("mid_rst_cout", {31'd0, cout}, 32'd0);
        do_op("after_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

`ifdef RCA_SEQ_SUB_EN
        sub = 1'b1;
        do_op("sub", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_nb", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0);
        sub = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/rca_seq_adder.md
Name: rca_seq_adder

Overview:
- Multi-cycle sequencer for wide additions using one shared 4-bit ripple-carry slice.
- The slice produces a per-bit carry vector.
- Accepts WIDTH-bit operands over a valid/ready handshake and walks them one nibble per cycle, LSB nibble first.
- Carries the slice carry-out between nibbles in a register and presents the full sum, carry-out and signed overflow on a held result handshake.
- Sits between operand producers and any wide-arithmetic consumer, where area matters more than latency.

Parameters:
- WIDTH, 16, operand and sum width. Must be a multiple of 4 and ≥4. NIB = WIDTH/4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start_valid  input  1  operand request
- start_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  initial carry-in
- sum_valid  output  1  result available
- sum_ready  input  1  consumer takes result
- sum  output  WIDTH  a+b+cin, low WIDTH bits
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE. sum, cout, ovf, sum_valid, busy, nibble index and carry register all 0. start_ready=1 after reset.
- Reset mid-RUN or mid-DONE: the operation is abandoned with no output, and the same reset values apply.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid & start_ready: capture a, b into operand registers, carry register <= cin, idx <= 0, sum cleared, go to RUN.
- RUN: each cycle the slice adds nibble idx of a and b with the carry register. Slice equations per bit: s = a^b^c, c_out = ((a^b)&c)|(a&b).
  - Result nibble is written to sum[4*idx+3:4*idx].
  - Carry register <= slice carry bit 3.
  - idx increments.
  - When idx == NIB-1: also latch cout = slice carry bit 3 and ovf = slice carry bit 2 XOR slice carry bit 3, then go to DONE.
- DONE:
  - sum_valid=1.
  - sum, cout and ovf are held stable until sum_ready is sampled high. The state then returns to IDLE on the next edge.
  - sum_valid falls in that same next cycle.
- Latency: accept edge at cycle T gives sum_valid high from cycle T+NIB. Minimum initiation interval is NIB+2 cycles, because start_ready is 0 in RUN and DONE.
- Operand inputs are ignored outside the accept cycle. Changing a, b or cin during RUN has no effect.
- sum_ready outside DONE is ignored.
- start_valid held through DONE is not accepted until IDLE.
- NIB=1 case: a single RUN cycle, then DONE.
- Wrap-around: the sum is truncated to WIDTH bits. Carry out is reported only on cout.
- sum, cout and ovf keep their last values after returning to IDLE; they are not cleared until the next accept.
- The slice is combinational inside the block. Only the state, idx, operand, carry and result registers are sequential.

Optional Feature:
- Macro: RCA_SEQ_SUB_EN
- When defined:
  - Adds input port sub (1 bit), captured at accept.
  - If sub=1: b is stored inverted and the carry register is initialised to 1, ignoring cin. sum = a-b, cout=1 means no borrow, ovf is signed subtraction overflow.
  - If sub=0: addition exactly as above.
- When undefined: the port is absent and the block only adds.

Test Plan:
- Basic add: WIDTH=16, a=0x1234, b=0x4321, cin=0. Required: sum=0x5555, cout=0, ovf=0, sum_valid rises exactly 4 cycles after the accept edge.
- Wrap-around: a=0xFFFF, b=0x0001, cin=0. Required: sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0. Required: sum=0x8000, cout=0, ovf=1.
- Backpressure: a=0x00FF, b=0x0001, cin=1, sum_ready held low 5 cycles.
  - Required: sum=0x0101 stable while sum_valid stays high.
  - Required: start_ready stays 0 and a start_valid pulse is ignored.
  - Raising sum_ready returns the block to IDLE next cycle.
- Reset mid-op: assert rst_n=0 at the second RUN cycle. Required: the next cycle has state IDLE, sum=0, sum_valid=0, start_ready=1. A new request then completes correctly.
- RCA_SEQ_SUB_EN build: a=0x0005, b=0x0007, sub=1. Required: sum=0xFFFE, cout=0, ovf=0.
